// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared types and constants for the 4-channel TDM
//                demultiplexer: FSM state encoding, number of slots per
//                frame and the slot index type.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package tdm_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

endpackage
`default_nettype wire

// File: rtl/tdm_demux_4ch_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_4ch_if
//  Description : Bundle of the TDM line inputs and the demultiplexed outputs.
//  Ports       : master - drives din/frame/en, observes channel outputs
//                slave  - the demultiplexer side
//                din, frame, en          : TDM line, slot-a marker, strobe
//                a, b, c, d              : demultiplexed channels
//                sel                     : expected slot of next sample
//                valid, lock, frame_err  : status
//  Revision    : 1.0  initial release
// ============================================================================
interface tdm_demux_4ch_if #(
  parameter int W = 1
);
  import tdm_pkg::*;

  logic [W-1:0] din;
  logic         frame;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  slot_t        sel;
  logic         valid;
  logic         lock;
  logic         frame_err;

  modport master (
    output din, frame, en,
    input  a, b, c, d, sel, valid, lock, frame_err
  );

  modport slave (
    input  din, frame, en,
    output a, b, c, d, sel, valid, lock, frame_err
  );

endinterface
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_slot_ctr
//  Description : Slot index counter. Priority: clear, load-to-1, advance.
//                Advancing from the last slot wraps back to slot 0.
//  Ports       : clk, rst  - clock, asynchronous active-high reset
//                en_i      - advance to next slot
//                load1_i   - force slot 1 (current sample taken as slot a)
//                clr_i     - force slot 0
//                slot_o    - current slot index
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en_i,
  input  logic  load1_i,
  input  logic  clr_i,
  output slot_t slot_o
);

  slot_t slot_q;
  slot_t slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = slot_t'(1);
    end else if (en_i) begin
      slot_d = (slot_q == slot_t'(NUM_SLOTS - 1)) ? '0 : slot_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule
`default_nettype wire

// File: rtl/tdm_demux_4ch.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_4ch
//  Description : 4-channel TDM demultiplexer with frame alignment.
//                Slots a..c are collected into shadow registers; the slot-d
//                sample loads all four channel outputs at once so a..d
//                always come from one complete frame. A HUNT/ACQ/LOCK FSM
//                tracks alignment using the frame marker.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                bus.din    - TDM line (W bits)
//                bus.frame  - high on the enabled slot-a sample
//                bus.en     - sample strobe
//                bus.a..d   - registered channel outputs
//                bus.sel    - expected slot index of next enabled sample
//                bus.valid  - one-cycle pulse when a..d update
//                bus.lock   - high while in LOCK
//                bus.frame_err - one-cycle pulse on a framing violation
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int W           = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  tdm_demux_4ch_if.slave    bus
);

  localparam int           CW       = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] LOCK_CNT = CW'(LOCK_FRAMES);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  sh0_q,   sh0_d;
  logic [W-1:0]  sh1_q,   sh1_d;
  logic [W-1:0]  sh2_q,   sh2_d;
  logic [W-1:0]  a_q,     a_d;
  logic [W-1:0]  b_q,     b_d;
  logic [W-1:0]  c_q,     c_d;
  logic [W-1:0]  d_q,     d_d;
  logic          valid_q, valid_d;
  logic          err_q,   err_d;

  logic          ctr_inc;
  logic          ctr_load1;
  logic          ctr_clr;
  slot_t         slot;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ctr_inc),
    .load1_i (ctr_load1),
    .clr_i   (ctr_clr),
    .slot_o  (slot)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    ctr_inc   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_clr   = 1'b0;

    if (bus.en) begin
      case (state_q)
        HUNT: begin
          if (bus.frame) begin
            sh0_d     = bus.din;
            ctr_load1 = 1'b1;
            cnt_d     = '0;
            state_d   = ACQ;
          end
        end

        ACQ, LOCK: begin
          if (slot == slot_t'(0)) begin
            if (!bus.frame) begin
              // Marker missing where slot a was expected: alignment lost.
              err_d   = 1'b1;
              cnt_d   = '0;
              ctr_clr = 1'b1;
              state_d = HUNT;
            end else begin
              sh0_d   = bus.din;
              ctr_inc = 1'b1;
            end
          end else if (bus.frame) begin
            // Marker arrived early: drop the partial frame and restart on
            // this sample as the new slot a. Stale shadows 1/2 are always
            // overwritten before the next slot-d completion.
            err_d     = 1'b1;
            sh0_d     = bus.din;
            ctr_load1 = 1'b1;
            cnt_d     = '0;
            state_d   = ACQ;
          end else begin
            ctr_inc = 1'b1;
            case (slot)
              slot_t'(1): sh1_d = bus.din;
              slot_t'(2): sh2_d = bus.din;
              default: begin
                a_d     = sh0_q;
                b_d     = sh1_q;
                c_d     = sh2_q;
                d_d     = bus.din;
                valid_d = 1'b1;
                if (state_q == ACQ) begin
                  if (cnt_q >= LOCK_CNT - CW'(1)) begin
                    cnt_d   = LOCK_CNT;
                    state_d = LOCK;
                  end else begin
                    cnt_d = cnt_q + CW'(1);
                  end
                end
              end
            endcase
          end
        end

        default: begin
          state_d = HUNT;
          cnt_d   = '0;
          ctr_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.d         = d_q;
  assign bus.sel       = slot;
  assign bus.valid     = valid_q;
  assign bus.lock      = (state_q == LOCK);
  assign bus.frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_4ch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux_4ch
//  Description : Self-checking bench for tdm_demux_4ch. A frame-level
//                reference model (queue of collected samples) predicts the
//                outputs after every clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tdm_demux_4ch;

  localparam int W           = 4;
  localparam int LOCK_FRAMES = 2;
  localparam int VW          = 4 * W + 5;

  logic clk;
  logic rst;

  tdm_demux_4ch_if #(.W(W)) bus ();

  tdm_demux_4ch #(.W(W), .LOCK_FRAMES(LOCK_FRAMES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  bit           m_aligned;
  bit           m_locked;
  int           m_good;
  logic [W-1:0] m_part [$];
  logic [W-1:0] m_out  [4];
  logic         m_valid;
  logic         m_err;

  function automatic void model_reset();
    m_aligned = 0;
    m_locked  = 0;
    m_good    = 0;
    m_part.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_valid = 0;
    m_err   = 0;
  endfunction

  function automatic logic [1:0] m_sel();
    int n;
    n = m_aligned ? m_part.size() : 0;
    return 2'(n);
  endfunction

  function automatic void model_step(input logic e, input logic f, input logic [W-1:0] dv);
    m_valid = 0;
    m_err   = 0;
    if (!e) return;
    if (!m_aligned) begin
      if (f) begin
        m_aligned = 1;
        m_good    = 0;
        m_part.delete();
        m_part.push_back(dv);
      end
      return;
    end
    if (m_part.size() == 0 && !f) begin
      m_err = 1; m_aligned = 0; m_locked = 0; m_good = 0;
      return;
    end
    if (m_part.size() != 0 && f) begin
      m_err = 1; m_locked = 0; m_good = 0;
      m_part.delete();
      m_part.push_back(dv);
      return;
    end
    m_part.push_back(dv);
    if (m_part.size() == 4) begin
      for (int i = 0; i < 4; i++) m_out[i] = m_part[i];
      m_valid = 1;
      m_part.delete();
      if (!m_locked) begin
        m_good++;
        if (m_good >= LOCK_FRAMES) m_locked = 1;
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_out[0], m_out[1], m_out[2], m_out[3], m_sel(), m_valid, m_locked, m_err};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.a, bus.b, bus.c, bus.d, bus.sel, bus.valid, bus.lock, bus.frame_err};
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model,
  // then settle away from the edge.
  task automatic tick(input logic e, input logic f, input logic [W-1:0] dv);
    bus.en    = e;
    bus.frame = f;
    bus.din   = dv;
    @(posedge clk);
    model_step(e, f, dv);
    #1;
  endtask

  task automatic apply_reset();
    bus.en = 0; bus.frame = 0; bus.din = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.en = 0; bus.frame = 0; bus.din = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== {VW{1'b0}})
      $display("FAIL reset_state: got %h want %h", obs_vec(), {VW{1'b0}});
    else n_pass++;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] vals [4];
    int nv;
    vals[0] = 0; vals[1] = 1; vals[2] = 1; vals[3] = 0;
    nv = 0;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 4; s++) begin
        tick(1'b1, s == 0, vals[s]);
        n_checks++;
        if (obs_vec() !== exp_vec())
          $display("FAIL basic f%0d s%0d: got %h want %h", f, s, obs_vec(), exp_vec());
        else n_pass++;
        if (bus.valid === 1'b1) nv++;
        if (s == 3) begin
          n_checks++;
          if (bus.lock !== (f >= 1))
            $display("FAIL basic_lock f%0d: got %b want %b", f, bus.lock, (f >= 1));
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (nv != 3) $display("FAIL basic_valid_count: got %0d want 3", nv);
    else n_pass++;
  endtask

  task automatic test_en_toggle();
    logic [W-1:0] vals [4];
    int cyc, last;
    vals[0] = 0; vals[1] = 1; vals[2] = 1; vals[3] = 0;
    apply_reset();
    cyc = 0; last = -1;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 4; s++) begin
        for (int h = 0; h < 2; h++) begin
          if (h == 0) tick(1'b1, s == 0, vals[s]);
          else        tick(1'b0, 1'($urandom), W'($urandom));
          cyc++;
          n_checks++;
          if (obs_vec() !== exp_vec())
            $display("FAIL en_toggle f%0d s%0d h%0d: got %h want %h", f, s, h, obs_vec(), exp_vec());
          else n_pass++;
          if (bus.valid === 1'b1) begin
            if (last >= 0) begin
              n_checks++;
              if (cyc - last != 8) $display("FAIL en_toggle_gap: got %0d want 8", cyc - last);
              else n_pass++;
            end
            last = cyc;
          end
        end
      end
    end
  endtask

  task automatic test_drop_frame();
    // Entered locked, at slot a, with outputs 0,1,1,0.
    tick(1'b1, 1'b0, W'($urandom));
    n_checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL drop_frame model: got %h want %h", obs_vec(), exp_vec());
    else n_pass++;
    n_checks++;
    if ({bus.frame_err, bus.lock, bus.valid, bus.sel} !== 5'b10000 ||
        {bus.a, bus.b, bus.c, bus.d} !== {W'(0), W'(1), W'(1), W'(0)})
      $display("FAIL drop_frame: got err=%b lock=%b valid=%b sel=%0d out=%h want 1 0 0 0 out=%h",
               bus.frame_err, bus.lock, bus.valid, bus.sel, {bus.a, bus.b, bus.c, bus.d},
               {W'(0), W'(1), W'(1), W'(0)});
    else n_pass++;
    tick(1'b1, 1'b0, W'($urandom));
    n_checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL drop_frame_after: got %h want %h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_early_frame();
    logic [W-1:0] nf [4];
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 4; s++) tick(1'b1, s == 0, W'($urandom));
    n_checks++;
    if (bus.lock !== 1'b1) $display("FAIL early_pre_lock: got %b want 1", bus.lock);
    else n_pass++;
    tick(1'b1, 1'b1, W'($urandom));
    tick(1'b1, 1'b0, W'($urandom));
    for (int i = 0; i < 4; i++) nf[i] = W'($urandom);
    for (int s = 0; s < 4; s++) begin
      tick(1'b1, s == 0, nf[s]);
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL early_frame s%0d: got %h want %h", s, obs_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (bus.valid !== (s == 3) || bus.frame_err !== (s == 0))
        $display("FAIL early_frame_flags s%0d: got valid=%b err=%b want %b %b",
                 s, bus.valid, bus.frame_err, (s == 3), (s == 0));
      else n_pass++;
    end
    n_checks++;
    if ({bus.a, bus.b, bus.c, bus.d} !== {nf[0], nf[1], nf[2], nf[3]})
      $display("FAIL early_frame_data: got %h want %h", {bus.a, bus.b, bus.c, bus.d},
               {nf[0], nf[1], nf[2], nf[3]});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int nv;
    for (int s = 0; s < 2; s++) tick(1'b1, s == 0, W'($urandom));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== {VW{1'b0}})
      $display("FAIL async_reset: got %h want %h", obs_vec(), {VW{1'b0}});
    else n_pass++;
    @(posedge clk);
    #3;
    rst = 1'b0;
    nv = 0;
    for (int s = 0; s < 2; s++) begin
      tick(1'b1, 1'b0, W'($urandom));
      if (bus.valid === 1'b1) nv++;
    end
    for (int s = 0; s < 4; s++) begin
      tick(1'b1, s == 0, W'($urandom));
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL async_reset_resume s%0d: got %h want %h", s, obs_vec(), exp_vec());
      else n_pass++;
      if (bus.valid === 1'b1) nv++;
    end
    n_checks++;
    if (nv != 1) $display("FAIL async_reset_valids: got %0d want 1", nv);
    else n_pass++;
  endtask

  task automatic test_hunt_noise();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, {W{1'b1}});
      n_checks++;
      if ({bus.sel, bus.valid, bus.frame_err, bus.lock} !== 5'b0 || obs_vec() !== exp_vec())
        $display("FAIL hunt_noise i%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic e, f;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(3) != 0);
      if (m_sel() == 2'd0) f = ($urandom_range(9) != 0);
      else                 f = ($urandom_range(19) == 0);
      tick(e, f, W'($urandom));
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random i%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 0; bus.frame = 0; bus.din = '0;
    model_reset();
    test_reset();
    test_basic();
    test_en_toggle();
    test_drop_frame();
    test_early_frame();
    test_async_reset();
    test_hunt_noise();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
